// File: rtl/diag_collector.sv
// De-skews seven anti-diagonal waves into a 4x4 row-major buffer, then drains it one row per handshake.
// Rows valid the cycle after wave 6 lands; a stalled row holds row_idx/row_data until row_ready.
module diag_collector #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wave_valid,
    input  logic [2:0]      wave_idx,
    input  logic [DW-1:0]   d1,
    input  logic [DW-1:0]   d2,
    input  logic [DW-1:0]   d3,
    input  logic [DW-1:0]   d4,
    output logic            wave_ready,
    output logic            row_valid,
    input  logic            row_ready,
    output logic [1:0]      row_idx,
    output logic [4*DW-1:0] row_data,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t      state, state_n;
    logic [2:0]  exp_wave, exp_wave_n;
    logic [1:0]  row_ptr, row_ptr_n;
    logic        done_n, err_n;
    logic        accept;

    logic [DW-1:0] m    [4][4];
    logic [DW-1:0] lane [4];
    logic [3:0]    base;
    logic [3:0]    rf     [4];
    logic [1:0]    wr_row [4];
    logic [1:0]    wr_col [4];
    logic [3:0]    wr_en;

    assign lane[0] = d1;
    assign lane[1] = d2;
    assign lane[2] = d3;
    assign lane[3] = d4;

    assign accept = (state == COLLECT) && wave_valid && (wave_idx == exp_wave);

    // Lane l of wave k lands on row base+l, column k-row; lanes past row 3 are idle.
    always_comb begin
        base = (wave_idx <= 3'd3) ? 4'd0 : ({1'b0, wave_idx} - 4'd3);
        for (int l = 0; l < 4; l++) begin
            rf[l]     = base + 4'(l);
            wr_row[l] = rf[l][1:0];
            wr_col[l] = wave_idx[1:0] - rf[l][1:0];
            wr_en[l]  = accept && (rf[l] <= 4'd3) && (rf[l] <= {1'b0, wave_idx});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    m[i][j] <= '0;
        end else begin
            for (int l = 0; l < 4; l++)
                if (wr_en[l])
                    m[wr_row[l]][wr_col[l]] <= lane[l];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= COLLECT;
            exp_wave <= 3'd0;
            row_ptr  <= 2'd0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            exp_wave <= exp_wave_n;
            row_ptr  <= row_ptr_n;
            done     <= done_n;
            err      <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        exp_wave_n = exp_wave;
        row_ptr_n  = row_ptr;
        done_n     = 1'b0;
        err_n      = err;
        case (state)
            COLLECT: begin
                if (wave_valid) begin
                    if (wave_idx == exp_wave) begin
                        if (exp_wave == 3'd6) begin
                            state_n    = DRAIN;
                            exp_wave_n = 3'd0;
                        end else begin
                            exp_wave_n = exp_wave + 3'd1;
                        end
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (row_ready) begin
                    if (row_ptr == 2'd3) begin
                        state_n   = COLLECT;
                        row_ptr_n = 2'd0;
                        done_n    = 1'b1;
                    end else begin
                        row_ptr_n = row_ptr + 2'd1;
                    end
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    assign wave_ready = (state == COLLECT);
    assign row_valid  = (state == DRAIN);
    assign busy       = (state == DRAIN) || (exp_wave != 3'd0);
    assign row_idx    = row_ptr;
    assign row_data   = {m[row_ptr][3], m[row_ptr][2], m[row_ptr][1], m[row_ptr][0]};

endmodule

// File: tb/tb_diag_collector.sv
// Directed bench for diag_collector: drives on negedge, samples on negedge.
module tb_diag_collector;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            wave_valid;
    logic [2:0]      wave_idx;
    logic [DW-1:0]   d1, d2, d3, d4;
    logic            wave_ready;
    logic            row_valid;
    logic            row_ready;
    logic [1:0]      row_idx;
    logic [4*DW-1:0] row_data;
    logic            busy;
    logic            done;
    logic            err;

    int pass_cnt = 0;
    int total    = 0;

    diag_collector #(.DW(DW)) dut (
        .clk(clk), .rst(rst),
        .wave_valid(wave_valid), .wave_idx(wave_idx),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4),
        .wave_ready(wave_ready),
        .row_valid(row_valid), .row_ready(row_ready),
        .row_idx(row_idx), .row_data(row_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] elem(input logic [7:0] tag, input int i, input int j);
        return {tag, 8'h00, 4'h0, 4'(i), 4'h0, 4'(j)};
    endfunction

    function automatic logic [127:0] exp_row(input logic [7:0] tag, input int i);
        return {elem(tag, i, 3), elem(tag, i, 2), elem(tag, i, 1), elem(tag, i, 0)};
    endfunction

    // Lane assignment written straight from the dispatcher's wavefront table.
    task automatic set_wave(input logic [7:0] tag, input int k);
        wave_valid = 1'b1;
        wave_idx   = 3'(k);
        d1 = 32'hDEAD_BEEF; d2 = 32'hDEAD_BEEF; d3 = 32'hDEAD_BEEF; d4 = 32'hDEAD_BEEF;
        if (k <= 3) begin
            d1 = elem(tag, 0, k);
            if (k >= 1) d2 = elem(tag, 1, k - 1);
            if (k >= 2) d3 = elem(tag, 2, k - 2);
            if (k == 3) d4 = elem(tag, 3, 0);
        end else begin
            d1 = elem(tag, k - 3, 3);
            if (k <= 5) d2 = elem(tag, k - 2, 2);
            if (k == 4) d3 = elem(tag, 3, 1);
        end
    endtask

    task automatic send_waves(input logic [7:0] tag, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            @(negedge clk);
            set_wave(tag, k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wave_valid = 1'b0; wave_idx = 3'd0; row_ready = 1'b0;
        d1 = '0; d2 = '0; d3 = '0; d4 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (wave_ready !== 1'b1) $display("FAIL reset_wave_ready got %b want 1", wave_ready); else pass_cnt++;
        total++; if (row_valid !== 1'b0) $display("FAIL reset_row_valid got %b want 0", row_valid); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL reset_done_err got %b%b want 00", done, err); else pass_cnt++;
        total++; if (row_data !== 128'd0) $display("FAIL reset_row_data got %h want 0", row_data); else pass_cnt++;
    endtask

    task automatic test_full_matrix();
        send_waves(8'h00, 0, 6);
        total++; if (row_valid !== 1'b0) $display("FAIL full_rv_early got %b want 0", row_valid); else pass_cnt++;
        total++; if (busy !== 1'b1) $display("FAIL full_busy got %b want 1", busy); else pass_cnt++;
        @(negedge clk);
        wave_valid = 1'b0;
        total++; if (row_valid !== 1'b1) $display("FAIL full_rv_rise got %b want 1", row_valid); else pass_cnt++;
        row_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (row_idx !== 2'(i) || row_data !== exp_row(8'h00, i))
                $display("FAIL full_row%0d got idx %0d data %h want idx %0d data %h", i, row_idx, row_data, i, exp_row(8'h00, i));
            else pass_cnt++;
            if (i == 2) begin
                total++;
                if (row_data !== 128'h00000203_00000202_00000201_00000200)
                    $display("FAIL full_row2_literal got %h", row_data);
                else pass_cnt++;
            end
            total++; if (done !== 1'b0) $display("FAIL full_done_early row%0d got %b want 0", i, done); else pass_cnt++;
            @(negedge clk);
        end
        row_ready = 1'b0;
        total++; if (done !== 1'b1 || row_valid !== 1'b0) $display("FAIL full_done got done %b rv %b want 1 0", done, row_valid); else pass_cnt++;
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL full_done_pulse got done %b busy %b want 0 0", done, busy); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [127:0] held;
        logic rr, exp_done, fin;
        int nxt;
        send_waves(8'h11, 0, 6);
        @(negedge clk);
        wave_valid = 1'b0;
        row_ready  = 1'b1;
        @(negedge clk);
        row_ready = 1'b0;
        held = row_data;
        total++; if (row_idx !== 2'd1 || held !== exp_row(8'h11, 1)) $display("FAIL bp_row1 got idx %0d data %h want 1 %h", row_idx, held, exp_row(8'h11, 1)); else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (row_idx !== 2'd1 || row_data !== held || row_valid !== 1'b1)
                $display("FAIL bp_stall%0d got idx %0d data %h rv %b want 1 %h 1", c, row_idx, row_data, row_valid, held);
            else pass_cnt++;
        end
        rr = 1'b0; exp_done = 1'b0; fin = 1'b0; nxt = 1;
        for (int c = 0; c < 30 && !fin; c++) begin
            if (c > 0) @(negedge clk);
            total++; if (done !== exp_done) $display("FAIL bp_done cyc%0d got %b want %b", c, done, exp_done); else pass_cnt++;
            if (exp_done) fin = 1'b1;
            exp_done = 1'b0;
            if (!fin) begin
                total++;
                if (row_valid !== 1'b1 || row_idx !== 2'(nxt) || row_data !== exp_row(8'h11, nxt))
                    $display("FAIL bp_row cyc%0d got idx %0d data %h want %0d %h", c, row_idx, row_data, nxt, exp_row(8'h11, nxt));
                else pass_cnt++;
                rr = ~rr;
                row_ready = rr;
                if (rr) begin
                    if (nxt == 3) exp_done = 1'b1;
                    nxt++;
                end
            end
        end
        row_ready = 1'b0;
        total++; if (!fin) $display("FAIL bp_timeout got no done want done"); else pass_cnt++;
    endtask

    task automatic test_wave_during_drain();
        send_waves(8'h22, 0, 6);
        @(negedge clk);
        set_wave(8'h99, 0);
        d1 = 32'hDEAD_BEEF; d2 = 32'hDEAD_BEEF; d3 = 32'hDEAD_BEEF; d4 = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        total++; if (wave_ready !== 1'b0 || err !== 1'b0 || row_idx !== 2'd0) $display("FAIL drainwave got wr %b err %b idx %0d want 0 0 0", wave_ready, err, row_idx); else pass_cnt++;
        wave_valid = 1'b0;
        row_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (row_idx !== 2'(i) || row_data !== exp_row(8'h22, i))
                $display("FAIL drainwave_row%0d got idx %0d data %h want %h", i, row_idx, row_data, exp_row(8'h22, i));
            else pass_cnt++;
            @(negedge clk);
        end
        row_ready = 1'b0;
        total++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL drainwave_done got done %b err %b want 1 0", done, err); else pass_cnt++;
    endtask

    task automatic test_seq_error();
        @(negedge clk);
        set_wave(8'h33, 0);
        @(negedge clk);
        set_wave(8'h33, 2);
        d1 = 32'hBAD0_0002; d2 = 32'hBAD0_0002; d3 = 32'hBAD0_0002; d4 = 32'hBAD0_0002;
        @(negedge clk);
        wave_valid = 1'b0;
        total++; if (err !== 1'b1 || busy !== 1'b1) $display("FAIL seqerr_flag got err %b busy %b want 1 1", err, busy); else pass_cnt++;
        send_waves(8'h33, 1, 6);
        @(negedge clk);
        wave_valid = 1'b0;
        total++; if (row_valid !== 1'b1) $display("FAIL seqerr_complete got rv %b want 1", row_valid); else pass_cnt++;
        row_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (row_data !== exp_row(8'h33, i))
                $display("FAIL seqerr_row%0d got %h want %h", i, row_data, exp_row(8'h33, i));
            else pass_cnt++;
            @(negedge clk);
        end
        row_ready = 1'b0;
        total++; if (err !== 1'b1 || done !== 1'b1) $display("FAIL seqerr_sticky got err %b done %b want 1 1", err, done); else pass_cnt++;
    endtask

    task automatic test_reset_mid_drain();
        send_waves(8'h44, 0, 6);
        @(negedge clk);
        wave_valid = 1'b0;
        row_ready  = 1'b1;
        repeat (2) @(negedge clk);
        row_ready = 1'b0;
        total++; if (row_idx !== 2'd2) $display("FAIL rstmid_pre got idx %0d want 2", row_idx); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total++; if (row_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) $display("FAIL rstmid_async got rv %b busy %b err %b want 0 0 0", row_valid, busy, err); else pass_cnt++;
        total++; if (wave_ready !== 1'b1 || row_idx !== 2'd0 || row_data !== 128'd0) $display("FAIL rstmid_state got wr %b idx %0d data %h want 1 0 0", wave_ready, row_idx, row_data); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (done !== 1'b0) $display("FAIL rstmid_nodone cyc%0d got %b want 0", c, done); else pass_cnt++;
        end
        send_waves(8'h55, 0, 6);
        @(negedge clk);
        wave_valid = 1'b0;
        row_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (row_idx !== 2'(i) || row_data !== exp_row(8'h55, i))
                $display("FAIL rstmid_row%0d got idx %0d data %h want %h", i, row_idx, row_data, exp_row(8'h55, i));
            else pass_cnt++;
            @(negedge clk);
        end
        row_ready = 1'b0;
        total++; if (done !== 1'b1) $display("FAIL rstmid_done got %b want 1", done); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        send_waves(8'h66, 0, 6);
        @(negedge clk);
        wave_valid = 1'b0;
        row_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (row_data !== exp_row(8'h66, i))
                $display("FAIL b2b_rowA%0d got %h want %h", i, row_data, exp_row(8'h66, i));
            else pass_cnt++;
            @(negedge clk);
        end
        row_ready = 1'b0;
        total++; if (done !== 1'b1 || wave_ready !== 1'b1) $display("FAIL b2b_done got done %b wr %b want 1 1", done, wave_ready); else pass_cnt++;
        set_wave(8'h77, 0);
        send_waves(8'h77, 1, 6);
        @(negedge clk);
        wave_valid = 1'b0;
        total++; if (row_valid !== 1'b1 || err !== 1'b0) $display("FAIL b2b_accept got rv %b err %b want 1 0", row_valid, err); else pass_cnt++;
        row_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (row_idx !== 2'(i) || row_data !== exp_row(8'h77, i))
                $display("FAIL b2b_rowB%0d got idx %0d data %h want %h", i, row_idx, row_data, exp_row(8'h77, i));
            else pass_cnt++;
            @(negedge clk);
        end
        row_ready = 1'b0;
        total++; if (done !== 1'b1) $display("FAIL b2b_doneB got %b want 1", done); else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_matrix();
        test_backpressure();
        test_wave_during_drain();
        test_seq_error();
        test_reset_mid_drain();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
